// File: rtl/onchip_mem_arbiter_if.sv
// Bus bundle between two Avalon-MM masters, the arbiter and the single-port RAM.
// Handshake: a master request (read or write) is accepted in any cycle where it is high and
// its m_waitrequest bit is low; reads return m_readdatavalid READ_LATENCY cycles later.
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [2*ADDR_W-1:0] m_address;
  logic [2*BE_W-1:0]   m_byteenable;
  logic [1:0]          m_read;
  logic [1:0]          m_write;
  logic [2*DATA_W-1:0] m_writedata;
  logic [1:0]          m_waitrequest;
  logic [DATA_W-1:0]   m_readdata;
  logic [1:0]          m_readdatavalid;

  logic [ADDR_W-1:0]   mem_address;
  logic [BE_W-1:0]     mem_byteenable;
  logic                mem_chipselect;
  logic                mem_write;
  logic [DATA_W-1:0]   mem_writedata;
  logic                mem_clken;
  logic [DATA_W-1:0]   mem_readdata;

  modport slave (
    input  m_address, m_byteenable, m_read, m_write, m_writedata, mem_readdata,
    output m_waitrequest, m_readdata, m_readdatavalid,
           mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
  );

  modport master (
    output m_address, m_byteenable, m_read, m_write, m_writedata, mem_readdata,
    input  m_waitrequest, m_readdata, m_readdatavalid,
           mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM.
// One access per cycle; read responses are routed back through a {valid, id} tag pipeline.
module onchip_mem_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset_n,
  onchip_mem_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;

  logic [1:0] rst_sync;
  logic       rst_ok;

  logic [1:0] req;
  logic       gnt_valid;
  logic       gnt_id;
  logic       last_grant;
  logic       rd_accept;

  logic [READ_LATENCY-1:0] tag_valid;
  logic [READ_LATENCY-1:0] tag_id;
  logic                    out_valid;
  logic                    out_id;

  // Reset asserts asynchronously, releases two clocks after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_ok = rst_sync[1];

  // A simultaneous read+write counts as a single write request.
  always_comb begin
    req       = bus.m_read | bus.m_write;
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (rst_ok) begin
      case (req)
        2'b01:   begin gnt_valid = 1'b1; gnt_id = 1'b0;        end
        2'b10:   begin gnt_valid = 1'b1; gnt_id = 1'b1;        end
        2'b11:   begin gnt_valid = 1'b1; gnt_id = ~last_grant; end
        default: begin gnt_valid = 1'b0; gnt_id = 1'b0;        end
      endcase
    end
  end

  assign rd_accept = gnt_valid & bus.m_read[gnt_id] & ~bus.m_write[gnt_id];

  always_comb begin
    bus.m_waitrequest  = 2'b00;
    bus.mem_chipselect = gnt_valid;
    bus.mem_write      = gnt_valid & bus.m_write[gnt_id];
    bus.mem_address    = gnt_id ? bus.m_address[2*ADDR_W-1:ADDR_W] : bus.m_address[ADDR_W-1:0];
    bus.mem_byteenable = gnt_id ? bus.m_byteenable[2*BE_W-1:BE_W] : bus.m_byteenable[BE_W-1:0];
    bus.mem_writedata  = gnt_id ? bus.m_writedata[2*DATA_W-1:DATA_W] : bus.m_writedata[DATA_W-1:0];
    if (!rst_ok)        bus.m_waitrequest = 2'b11;
    else if (gnt_valid) bus.m_waitrequest = gnt_id ? 2'b01 : 2'b10;
  end

  // Depth equals the RAM latency, so an accepted read can never be lost to overflow.
  always_ff @(posedge clk or negedge rst_ok) begin
    if (!rst_ok) begin
      tag_valid  <= '0;
      tag_id     <= '0;
      last_grant <= 1'b1;
    end else begin
      tag_valid[0] <= rd_accept;
      tag_id[0]    <= gnt_id;
      for (int s = 1; s < READ_LATENCY; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end
      if (gnt_valid) last_grant <= gnt_id;
    end
  end

  assign out_valid           = tag_valid[READ_LATENCY-1];
  assign out_id              = tag_id[READ_LATENCY-1];
  assign bus.m_readdatavalid = out_valid ? (out_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.m_readdata      = out_valid ? bus.mem_readdata : '0;
  assign bus.mem_clken       = rst_ok;
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Drives one stimulus stream into a latency-1 and a latency-3 arbiter, each with its own RAM,
// and checks both against a cycle-level reference model with per-build response queues.
module tb_onchip_mem_arbiter;
  typedef logic [48:0] exp_t; // {due_cycle[15:0], id, data[31:0]}

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  rd, wr;
  logic [10:0] ad [2];
  logic [3:0]  be [2];
  logic [31:0] wd [2];

  onchip_mem_arbiter_if #(.ADDR_W(11), .DATA_W(32)) bus1 ();
  onchip_mem_arbiter_if #(.ADDR_W(11), .DATA_W(32)) bus3 ();

  onchip_mem_arbiter #(.ADDR_W(11), .DATA_W(32), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1));
  onchip_mem_arbiter #(.ADDR_W(11), .DATA_W(32), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3));

  // clock / reset
  always #5 clk = ~clk;

  assign bus1.m_address    = {ad[1], ad[0]};
  assign bus1.m_byteenable = {be[1], be[0]};
  assign bus1.m_read       = rd;
  assign bus1.m_write      = wr;
  assign bus1.m_writedata  = {wd[1], wd[0]};
  assign bus3.m_address    = {ad[1], ad[0]};
  assign bus3.m_byteenable = {be[1], be[0]};
  assign bus3.m_read       = rd;
  assign bus3.m_write      = wr;
  assign bus3.m_writedata  = {wd[1], wd[0]};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] b,
                                        input logic [31:0] d);
    merge = old;
    for (int i = 0; i < 4; i++) if (b[i]) merge[i*8 +: 8] = d[i*8 +: 8];
  endfunction

  // RAM stand-ins: latency 1 and latency 3
  logic [31:0] ram1 [2048];
  logic [31:0] ram3 [2048];
  logic [31:0] q1, q3a, q3b, q3c;

  always @(posedge clk) begin
    if (bus1.mem_clken && bus1.mem_chipselect) begin
      if (bus1.mem_write) ram1[bus1.mem_address] <= merge(ram1[bus1.mem_address], bus1.mem_byteenable, bus1.mem_writedata);
      else                q1 <= ram1[bus1.mem_address];
    end
    if (bus3.mem_clken && bus3.mem_chipselect) begin
      if (bus3.mem_write) ram3[bus3.mem_address] <= merge(ram3[bus3.mem_address], bus3.mem_byteenable, bus3.mem_writedata);
      else                q3a <= ram3[bus3.mem_address];
    end
    q3b <= q3a;
    q3c <= q3b;
  end
  assign bus1.mem_readdata = q1;
  assign bus3.mem_readdata = q3c;

  // reference model + scoreboard
  logic [31:0] ref_mem [2048];
  exp_t        exp_q1[$];
  exp_t        exp_q3[$];
  logic        last_g;
  logic        ready;
  int          sync_cnt;
  int          cyc;
  int          total, bad;
  int          vcnt [2][2];
  logic [31:0] last_rd [2];
  logic [1:0]  last_wait [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic drive(input int m, input logic r, input logic w, input logic [10:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    rd[m] = r; wr[m] = w; ad[m] = a; be[m] = b; wd[m] = d;
  endtask

  task automatic idle();
    rd = 2'b00; wr = 2'b00;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    logic [1:0]  req, exp_wait, ow, orv, exp_v;
    logic        gv, g, hit;
    logic [31:0] od, rdata;
    exp_t        e;
    string       p;
    #2;
    if (!reset_n) begin
      sync_cnt = 0; ready = 1'b0; last_g = 1'b1;
      exp_q1.delete(); exp_q3.delete();
    end
    req = rd | wr;
    gv = 1'b0; g = 1'b0;
    if (ready && req != 2'b00) begin
      gv = 1'b1;
      g  = (req == 2'b11) ? ~last_g : req[1];
    end
    exp_wait = !ready ? 2'b11 : (!gv ? 2'b00 : (g ? 2'b01 : 2'b10));
    for (int k = 0; k < 2; k++) begin
      p  = k ? "L3" : "L1";
      ow = k ? bus3.m_waitrequest : bus1.m_waitrequest;
      check({p, " waitrequest"}, 32'(ow), 32'(exp_wait));
      check({p, " chipselect"}, 32'(k ? bus3.mem_chipselect : bus1.mem_chipselect), 32'(gv));
      check({p, " mem_write"}, 32'(k ? bus3.mem_write : bus1.mem_write), 32'(gv & wr[g]));
      check({p, " clken"}, 32'(k ? bus3.mem_clken : bus1.mem_clken), 32'(ready));
      if (gv) begin
        check({p, " mem_address"}, 32'(k ? bus3.mem_address : bus1.mem_address), 32'(ad[g]));
        check({p, " mem_byteenable"}, 32'(k ? bus3.mem_byteenable : bus1.mem_byteenable), 32'(be[g]));
        check({p, " mem_writedata"}, k ? bus3.mem_writedata : bus1.mem_writedata, wd[g]);
      end
      hit = 1'b0; e = '0;
      if (k == 0 && exp_q1.size() > 0 && exp_q1[0][48:33] == cyc[15:0]) begin
        e = exp_q1.pop_front(); hit = 1'b1;
      end
      if (k == 1 && exp_q3.size() > 0 && exp_q3[0][48:33] == cyc[15:0]) begin
        e = exp_q3.pop_front(); hit = 1'b1;
      end
      exp_v = !hit ? 2'b00 : (e[32] ? 2'b10 : 2'b01);
      orv   = k ? bus3.m_readdatavalid : bus1.m_readdatavalid;
      od    = k ? bus3.m_readdata : bus1.m_readdata;
      check({p, " readdatavalid"}, 32'(orv), 32'(exp_v));
      vcnt[k][0] += int'(orv[0]);
      vcnt[k][1] += int'(orv[1]);
      if (hit) begin
        check({p, " readdata"}, od, e[31:0]);
        last_rd[k] = od;
      end else if (!ready) begin
        check({p, " readdata_in_reset"}, od, 32'h0);
      end
      last_wait[k] = ow;
    end
    @(posedge clk);
    if (gv) begin
      if (wr[g]) begin
        ref_mem[ad[g]] = merge(ref_mem[ad[g]], be[g], wd[g]);
      end else begin
        rdata = ref_mem[ad[g]];
        exp_q1.push_back({16'(cyc + 1), g, rdata});
        exp_q3.push_back({16'(cyc + 3), g, rdata});
      end
      last_g = g;
    end
    if (reset_n && sync_cnt < 2) sync_cnt++;
    ready = (sync_cnt >= 2);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] w;
    int r;
    total = 0; bad = 0; cyc = 0; sync_cnt = 0; ready = 1'b0; last_g = 1'b1;
    reset_n = 1'b0;
    rd = 2'b00; wr = 2'b00;
    for (int m = 0; m < 2; m++) begin ad[m] = '0; be[m] = '0; wd[m] = '0; vcnt[0][m] = 0; vcnt[1][m] = 0; end
    for (int i = 0; i < 2048; i++) begin
      w = $urandom; ram1[i] = w; ram3[i] = w; ref_mem[i] = w;
    end
    @(negedge clk);

    // reset with both masters requesting, then synchronizer release
    drive(0, 1, 0, 11'h001, 4'hF, 0);
    drive(1, 1, 0, 11'h002, 4'hF, 0);
    repeat (3) step();
    reset_n = 1'b1;
    idle();
    repeat (2) step();
    check("clken_after_release", 32'(bus1.mem_clken), 32'h1);

    // test 1: write then read back
    drive(0, 0, 1, 11'h005, 4'hF, 32'hDEADBEEF); step();
    drive(0, 1, 0, 11'h005, 4'hF, 32'h0);        step();
    idle(); repeat (3) step();
    check("t1_readback_l1", last_rd[0], 32'hDEADBEEF);
    check("t1_readback_l3", last_rd[1], 32'hDEADBEEF);

    // test 2: both masters reading continuously
    drive(0, 0, 1, 11'h010, 4'hF, 32'hA0A0A0A0); step();
    idle();
    drive(1, 0, 1, 11'h020, 4'hF, 32'hB1B1B1B1); step();
    for (int k = 0; k < 2; k++) for (int m = 0; m < 2; m++) vcnt[k][m] = 0;
    drive(0, 1, 0, 11'h010, 4'hF, 0);
    drive(1, 1, 0, 11'h020, 4'hF, 0);
    repeat (8) step();
    idle(); repeat (3) step();
    for (int k = 0; k < 2; k++) for (int m = 0; m < 2; m++)
      check($sformatf("t2_valid_count_k%0d_m%0d", k, m), 32'(vcnt[k][m]), 32'd4);

    // test 3: byte-lane merge by the other master
    drive(0, 0, 1, 11'h030, 4'hF, 32'h11223344); step();
    idle();
    drive(1, 0, 1, 11'h030, 4'b0010, 32'h0000AB00); step();
    idle();
    drive(0, 1, 0, 11'h030, 4'hF, 0); step();
    idle(); repeat (3) step();
    check("t3_merge_l1", last_rd[0], 32'h1122AB44);
    check("t3_merge_l3", last_rd[1], 32'h1122AB44);

    // test 4: read+write together is a write
    drive(0, 1, 1, 11'h7FF, 4'hF, 32'h12345678); step();
    idle(); repeat (3) step();
    drive(0, 1, 0, 11'h7FF, 4'hF, 0); step();
    idle(); repeat (3) step();
    check("t4_rw_is_write_l1", last_rd[0], 32'h12345678);
    check("t4_rw_is_write_l3", last_rd[1], 32'h12345678);

    // test 5: reset right after an accepted read drops its response
    drive(1, 1, 0, 11'h020, 4'hF, 0); step();
    idle();
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (4) step();
    drive(0, 1, 0, 11'h010, 4'hF, 0);
    drive(1, 1, 0, 11'h020, 4'hF, 0);
    step();
    check("t5_first_contested_grant", 32'(last_wait[0]), 32'(2'b10));
    idle(); repeat (3) step();

    // test 6 and random traffic, with one reset in the middle
    for (int n = 0; n < 400; n++) begin
      for (int m = 0; m < 2; m++) begin
        r = $urandom_range(0, 3);
        drive(m, (r == 1 || r == 3), (r >= 2),
              ($urandom_range(0, 15) == 0) ? 11'h7FF : 11'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), $urandom);
      end
      if (n == 200) reset_n = 1'b0;
      if (n == 203) reset_n = 1'b1;
      step();
    end
    idle(); repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
Two-master round-robin arbiter for the single-port on-chip RAM (11-bit word address, 32-bit data, 4 byte lanes, 1-cycle read latency). It sits between the Nios data master and a secondary master (e.g. DMA) and the RAM slave port. It presents each master an Avalon-MM slave with waitrequest and readdatavalid, and issues at most one memory access per cycle.

Parameters:
ADDR_W, 11, word address width
DATA_W, 32, data width; byte lanes = DATA_W/8
READ_LATENCY, 1, cycles from accepted read to valid mem_readdata (1..4)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m_address  in  2*ADDR_W  master i address at [i*ADDR_W +: ADDR_W]
m_byteenable  in  2*DATA_W/8  master i byte enables
m_read  in  2  read request per master
m_write  in  2  write request per master
m_writedata  in  2*DATA_W  master i write data
m_waitrequest  out  2  stall per master
m_readdata  out  DATA_W  read data, shared by both masters
m_readdatavalid  out  2  read data valid per master
mem_address  out  ADDR_W  RAM address
mem_byteenable  out  DATA_W/8  RAM byte enables
mem_chipselect  out  1  RAM select
mem_write  out  1  RAM write
mem_writedata  out  DATA_W  RAM write data
mem_clken  out  1  RAM clock enable
mem_readdata  in  DATA_W  RAM read data

Behaviour:
- Reset (async assert, sync deassert inside the block via a 2-flop synchronizer): m_waitrequest=2'b11, m_readdatavalid=0, m_readdata=0, mem_chipselect=0, mem_write=0, mem_clken=0, last_grant=1, read tag pipeline cleared.
- The first cycle after the synchronizer releases: mem_clken=1 and stays 1.
- req[i] = m_read[i] | m_write[i]. If read and write are both high, the request is a write and the read is ignored.
- Grant is combinational each cycle:
  - Only one requester: grant it.
  - Both request: grant the master != last_grant.
  - last_grant updates on every grant.
- Granted master: m_waitrequest[i]=0, and its address, byteenable and writedata drive the mem_* outputs. mem_chipselect=1; mem_write=m_write[i].
- Non-granted master: m_waitrequest=1.
- Idle (no request): mem_chipselect=0, mem_write=0, m_waitrequest=2'b00 (no request is pending).
- Write completes in the accept cycle; there is no response.
- Read tag pipeline is READ_LATENCY stages of {valid, id}:
  - Stage 0 loads {1, i} on an accepted read and {0, x} otherwise.
  - At the last stage: m_readdatavalid[id]=1 and m_readdata=mem_readdata, registered with 0 added latency, i.e. combinational from mem_readdata.
  - Total read latency to the master = READ_LATENCY cycles after the accept edge.
- Back-to-back reads from either master are accepted every cycle. Pipeline depth equals latency, so no overflow is possible.
- Read-after-write to the same address from the other master next cycle returns the new data (RAM write completes at the edge).
- When both masters hold their requests, grants strictly alternate: 0,1,0,1.
- Reset mid-read: pending readdatavalid is dropped and never asserted; no spurious valid after release.
- m_readdatavalid is never high for both masters in one cycle.

Test Plan:
1. Reset release, m0 writes 0xDEADBEEF to addr 0x005 (be=4'hF), then reads 0x005 -> write accepted cycle 0 with waitrequest=0. Read accepted cycle 1; m_readdatavalid=2'b01 one cycle later with readdata 0xDEADBEEF.
2. Both masters read continuously (m0 addr 0x010, m1 addr 0x020) for 8 cycles -> grants alternate 0,1,0,1… starting with m0. Each master gets 4 readdatavalids carrying its own data; waitrequest toggles accordingly.
3. m1 writes be=4'b0010 data 0x0000AB00 to a location holding 0x11223344, then m0 reads it -> m0 gets 0x1122AB44.
4. m0 asserts read and write together, addr 0x7FF, data 0x12345678 -> treated as a write. No readdatavalid; a subsequent read returns 0x12345678.
5. reset_n asserted one cycle after an m1 read is accepted -> no m_readdatavalid. During reset m_waitrequest=2'b11, mem_chipselect=0. After release, m0 wins the first contested grant.
6. READ_LATENCY=3 build, m0/m1 interleaved reads -> each valid arrives exactly 3 cycles after its accept, routed to the correct master.
